am_demod: RTL
=============

# am_demod

AM envelope demodulator: the receive-side counterpart of the AM modulator in this design. It accepts the modulator's signed 16-bit product stream, one sample per clock, and full-wave rectifies it. It then integrates the rectified samples over a fixed window of 2^LOG2_N samples and emits the recovered 8-bit baseband envelope plus the window peak, with a one-cycle valid strobe per window. It sits directly downstream of the modulator output (or of any 16-bit AM sample source) in loopback and test builds.

## Interface

- Clock and reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - LOG2_N, default 5: window length is N = 2^LOG2_N samples. The window must span an integer number of carrier periods.
  - OUT_SHIFT, default 7: extra right shift applied after averaging. It scales the mean |x| into the 8-bit envelope range.
- Ports:
  - clk  in  1  system clock; one AM sample per rising edge.
  - rst_n  in  1  asynchronous active-low reset.
  - am_in  in  16  signed AM sample, two's complement.
  - env_out  out  8  unsigned recovered envelope; held between windows.
  - peak_out  out  16  unsigned max |am_in| seen in the last completed window.
  - env_valid  out  1  single-cycle strobe; env_out and peak_out are updated in the same cycle.

## Operation

- Stage 1 (rectify): abs_r <= |am_in| as 16-bit unsigned. The result for -32768 is 32768, with no overflow.
- Stage 2 (integrate):
  - acc has width 16+LOG2_N, unsigned; cnt has width LOG2_N.
  - On every edge: acc <= acc + abs_r, pk <= max(pk, abs_r), cnt <= cnt + 1, with natural wrap-around.
- Window close, on the edge where cnt == N-1:
  - sum = acc + abs_r.
  - env_out <= sat8(sum >> (LOG2_N + OUT_SHIFT)). Truncate toward zero; saturate to 255 if any higher bit is set.
  - peak_out <= max(pk, abs_r).
  - acc <= 0 and pk <= 0. The closing sample belongs to the closed window and is not carried into the next.
- FSM, two states:
  - WARMUP (reset state): the first window after reset closes normally, but env_out, peak_out and env_valid are not updated. This window contains the reset-zero abs_r. Transition to RUN at that close.
  - RUN: every window close drives env_valid = 1 for exactly one cycle. The state stays RUN until reset.
- Reset values: env_out = 0, peak_out = 0, env_valid = 0, abs_r = 0, acc = 0, pk = 0, cnt = 0, state = WARMUP.
- Reset asserted mid-window: all state clears immediately. The partial window is discarded, and after release the block repeats WARMUP.
- No input handshake: every edge consumes one sample. Backpressure is not supported, and env_valid is not acknowledged.

## Timing

- Numbering: edge 1 is the first rising edge after rst_n deasserts.
- Edges 1..N form the WARMUP window. Edges N+1..2N form the first RUN window; it integrates samples presented at edges N..2N-1.
- env_valid is high in the cycle after edge 2N, then every N cycles thereafter. It is never high on consecutive cycles when N ≥ 2.
- Input-to-output latency: one pipeline cycle plus the window. A step on am_in is fully reflected in the second valid after the step.
- env_out and peak_out are registered and stable from one valid to the next.

## Structure

- Shared package am_pkg holds:
  - AM_W = 16 (sample width) and ENV_W = 8 (envelope width). These are shared with the modulator side.
  - The FSM state enum {WARMUP, RUN}.
- One natural sub-module: am_rectify. It is a registered abs with one-cycle latency, 16-bit signed in and 16-bit unsigned out. It is reusable by other receive paths.
- The accumulator, counter, peak tracker and FSM stay in am_demod.

## Test plan

All scenarios use LOG2_N = 4 and OUT_SHIFT = 2 unless noted.

- Constant am_in = 1000 -> sum = 16000 >> 6 = 250. env_out = 250 and peak_out = 1000 at the first valid, which falls in the cycle after edge 32.
- Constant am_in = -1000 -> identical result (env_out = 250, peak_out = 1000), confirming symmetric rectification.
- Constant am_in = -32768 -> the sum exceeds 8 bits after the shift, so env_out = 255 (saturated) and peak_out = 32768.
- Loopback with defaults (LOG2_N = 5, OUT_SHIFT = 7): drive the modulator with cos_s = 200 and a 32-sample carrier of amplitude 127 -> env_out is within ±2 of floor(mean|200·c| / 128), computed by the reference model. env_valid occurs every 32 cycles.
- Step am_in from 0 to 4000 mid-window -> the first valid after the step shows a partial average, and the second shows exactly 4000·16 >> 6 = 1000, saturated to 255.
- Reset pulse mid-window, with am_in = 1000 throughout -> outputs go to 0 immediately. No env_valid appears for 32 cycles after release; the next valid shows env_out = 250.

Source files
------------

// File: rtl/am_pkg.sv
// Shared AM datapath constants and demodulator state type.
// Sample and envelope widths are common to the modulator and demodulator sides.
package am_pkg;
  localparam int AM_W  = 16;
  localparam int ENV_W = 8;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } am_state_e;
endpackage

// File: rtl/am_rectify.sv
// Registered full-wave rectifier: signed sample in, unsigned magnitude out one cycle later.
// -32768 maps to 32768, which still fits the unsigned output.
module am_rectify
  import am_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [AM_W-1:0] sample_i,
  output logic        [AM_W-1:0] abs_o
);

  logic [AM_W-1:0] raw;
  logic [AM_W-1:0] abs_d;
  logic [AM_W-1:0] abs_q;

  assign raw = sample_i;

  always_comb begin
    abs_d = raw;
    if (raw[AM_W-1]) begin
      abs_d = ~raw + AM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_q <= '0;
    end else begin
      abs_q <= abs_d;
    end
  end

  assign abs_o = abs_q;

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: rectify, integrate over 2^LOG2_N samples, emit envelope and peak.
//   state  | meaning
//   WARMUP | first window after reset; closes silently (holds the reset-zero sample)
//   RUN    | every window close publishes env_out/peak_out with a one-cycle env_valid
module am_demod
  import am_pkg::*;
#(
  parameter int LOG2_N    = 5,
  parameter int OUT_SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [AM_W-1:0]  am_in,
  output logic        [ENV_W-1:0] env_out,
  output logic        [AM_W-1:0]  peak_out,
  output logic                    env_valid
);

  localparam int ACC_W = AM_W + LOG2_N;
  localparam int SHIFT = LOG2_N + OUT_SHIFT;

  logic [AM_W-1:0]   abs_r;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AM_W-1:0]   pk_q, pk_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  am_state_e         state_q, state_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic [AM_W-1:0]   peak_q, peak_d;
  logic              valid_q, valid_d;

  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  scaled;
  logic [ENV_W-1:0]  env_sat;
  logic [AM_W-1:0]   pk_max;
  logic              win_close;

  am_rectify u_rectify (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (am_in),
    .abs_o    (abs_r)
  );

  // The closing sample is folded into the window it closes, never into the next one.
  assign sum       = acc_q + ACC_W'(abs_r);
  assign scaled    = sum >> SHIFT;
  assign env_sat   = (scaled > ACC_W'((1 << ENV_W) - 1)) ? {ENV_W{1'b1}} : scaled[ENV_W-1:0];
  assign pk_max    = (abs_r > pk_q) ? abs_r : pk_q;
  assign win_close = &cnt_q;

  always_comb begin
    acc_d   = sum;
    pk_d    = pk_max;
    cnt_d   = cnt_q + LOG2_N'(1);
    state_d = state_q;
    env_d   = env_q;
    peak_d  = peak_q;
    valid_d = 1'b0;
    if (win_close) begin
      acc_d = '0;
      pk_d  = '0;
      case (state_q)
        WARMUP: state_d = RUN;
        RUN: begin
          env_d   = env_sat;
          peak_d  = pk_max;
          valid_d = 1'b1;
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      pk_q    <= '0;
      cnt_q   <= '0;
      state_q <= WARMUP;
      env_q   <= '0;
      peak_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      pk_q    <= pk_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      env_q   <= env_d;
      peak_q  <= peak_d;
      valid_q <= valid_d;
    end
  end

  assign env_out   = env_q;
  assign peak_out  = peak_q;
  assign env_valid = valid_q;

endmodule
